// File: rtl/amult_sched.sv
// amult_sched: round-robin arbiter in front of one serial shift-add multiplier.
// Each operand pair takes SHIFT cycles; the result is held until it is accepted.
module amult_sched #(
    parameter int WIDTH = 32,
    parameter int SHIFT = 16,
    parameter int NREQ  = 4,
    parameter int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NREQ-1:0]       REQ_VALID,
    output logic [NREQ-1:0]       REQ_READY,
    input  logic [NREQ*WIDTH-1:0] REQ_DATA,
    input  logic [NREQ*SHIFT-1:0] REQ_SHIFT,
    output logic                  RES_VALID,
    input  logic                  RES_READY,
    output logic [WIDTH-1:0]      RES_DATA,
    output logic [IDW-1:0]        RES_ID,
    output logic                  BUSY
);

    localparam int CW = (SHIFT > 1) ? $clog2(SHIFT) : 1;
    localparam int SW = CW + 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   gnt_id;
    logic [IDW-1:0]   win;
    logic             found;
    logic [WIDTH-1:0] op_data;
    logic [SHIFT-1:0] op_shift;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] term;
    logic [CW-1:0]    cnt;
    logic [SW-1:0]    sh_amt;
    logic             last;
    logic             bit_set;
    int               idx;

    // Scan requesters starting at ptr; the first valid one wins.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && REQ_VALID[idx]) begin
                win   = IDW'(idx);
                found = 1'b1;
            end
        end
    end

    // Grant strobe exists only in IDLE and never during reset.
    always_comb begin
        REQ_READY = '0;
        if (state == IDLE && !RST && found) REQ_READY[win] = 1'b1;
    end

    // Current partial-product term: operand shifted by cnt+1, sign preserved.
    always_comb begin
        sh_amt  = SW'(cnt) + SW'(1);
        term    = $signed(op_data) >>> sh_amt;
        bit_set = op_shift[CW'(SHIFT - 1) - cnt];
        last    = (cnt == CW'(SHIFT - 1));
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (found) state_nxt = CALC;
            CALC:    if (last) state_nxt = DONE;
            DONE:    if (RES_READY) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register plus operand latch, accumulator and round-robin pointer.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            ptr      <= '0;
            gnt_id   <= '0;
            op_data  <= '0;
            op_shift <= '0;
            acc      <= '0;
            cnt      <= '0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        op_data  <= REQ_DATA[int'(win)*WIDTH +: WIDTH];
                        op_shift <= REQ_SHIFT[int'(win)*SHIFT +: SHIFT];
                        gnt_id   <= win;
                        acc      <= '0;
                        cnt      <= '0;
                    end
                end
                CALC: begin
                    if (bit_set) acc <= acc + term;
                    cnt <= cnt + CW'(1);
                end
                DONE: begin
                    if (RES_READY) begin
                        if (gnt_id == IDW'(NREQ - 1)) ptr <= '0;
                        else ptr <= gnt_id + IDW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign RES_VALID = (state == DONE);
    assign RES_DATA  = acc;
    assign RES_ID    = gnt_id;
    assign BUSY      = (state != IDLE);

endmodule

// File: tb/tb_amult_sched.sv
// Directed bench for amult_sched: single ops, sign, arbitration, fairness,
// backpressure and reset during an operation.
module tb_amult_sched;

    logic         CLK = 1'b0;
    logic         RST;
    logic [3:0]   REQ_VALID;
    logic [3:0]   REQ_READY;
    logic [127:0] REQ_DATA;
    logic [63:0]  REQ_SHIFT;
    logic         RES_VALID;
    logic         RES_READY;
    logic [31:0]  RES_DATA;
    logic [1:0]   RES_ID;
    logic         BUSY;

    int total = 0;
    int bad   = 0;

    amult_sched dut (
        .CLK(CLK), .RST(RST),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_DATA(REQ_DATA), .REQ_SHIFT(REQ_SHIFT),
        .RES_VALID(RES_VALID), .RES_READY(RES_READY),
        .RES_DATA(RES_DATA), .RES_ID(RES_ID), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    // Inputs change at edge+1, outputs are sampled at edge+2.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [31:0] d,
                           input logic [15:0] s);
        REQ_DATA[i*32 +: 32]  = d;
        REQ_SHIFT[i*16 +: 16] = s;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        REQ_VALID = '0;
        RES_READY = 1'b0;
        tick();
        tick();
        RST = 1'b0;
    endtask

    // Wait for a grant, check it, then step past the handshake edge.
    task automatic grant(input int exp_id);
        int n;
        n = 0;
        #1;
        while (REQ_READY == 4'b0 && n < 40) begin
            tick();
            #1;
            n++;
        end
        chk($sformatf("grant%0d", exp_id), {28'b0, REQ_READY},
            32'(4'b1 << exp_id));
        tick();
    endtask

    // Called at T+1; waits for the result, checks it and accepts it.
    task automatic finish(input int exp_id, input logic [31:0] exp_d,
                          input bit chk_lat);
        int n;
        n = 1;
        #1;
        chk("busy_calc", {31'b0, BUSY}, 32'd1);
        while (!RES_VALID && n < 40) begin
            tick();
            #1;
            n++;
        end
        if (chk_lat) chk("latency", n, 32'd17);
        chk("res_valid", {31'b0, RES_VALID}, 32'd1);
        chk("res_data", RES_DATA, exp_d);
        chk("res_id", {30'b0, RES_ID}, 32'(exp_id));
        RES_READY = 1'b1;
        tick();
        RES_READY = 1'b0;
        #1;
        chk("res_drop", {31'b0, RES_VALID}, 32'd0);
    endtask

    task automatic single(input logic [31:0] d, input logic [15:0] s,
                          input logic [31:0] exp_d);
        set_req(0, d, s);
        REQ_VALID = 4'b0001;
        grant(0);
        REQ_VALID = '0;
        finish(0, exp_d, 1'b1);
    endtask

    initial begin
        logic [31:0] hold_d;
        logic [1:0]  hold_id;
        REQ_DATA  = '0;
        REQ_SHIFT = '0;
        do_reset();
        #1;
        chk("rst_ready", {28'b0, REQ_READY}, 32'd0);
        chk("rst_valid", {31'b0, RES_VALID}, 32'd0);
        chk("rst_data", RES_DATA, 32'd0);
        chk("rst_id", {30'b0, RES_ID}, 32'd0);
        chk("rst_busy", {31'b0, BUSY}, 32'd0);

        single(32'h0001_0000, 16'h8000, 32'h0000_8000);
        single(32'h0001_0000, 16'hC000, 32'h0000_C000);
        single(32'h0001_0000, 16'hFFFF, 32'h0000_FFFF);
        single(32'h0001_0000, 16'h0000, 32'h0000_0000);
        single(32'hFFFF_0000, 16'h8000, 32'hFFFF_8000);
        single(32'h8000_0000, 16'h8000, 32'hC000_0000);

        // All four requesting: strict rotation from 0.
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 32'(i + 1) << 16, 16'h8000);
        REQ_VALID = 4'b1111;
        grant(0); finish(0, 32'h0000_8000, 1'b0);
        grant(1); finish(1, 32'h0001_0000, 1'b0);
        grant(2); finish(2, 32'h0001_8000, 1'b0);
        grant(3); finish(3, 32'h0002_0000, 1'b0);
        grant(0); finish(0, 32'h0000_8000, 1'b0);

        // Only 1 and 3 requesting: they alternate.
        do_reset();
        REQ_VALID = 4'b1010;
        grant(1); finish(1, 32'h0001_0000, 1'b0);
        grant(3); finish(3, 32'h0002_0000, 1'b0);
        grant(1); finish(1, 32'h0001_0000, 1'b0);
        grant(3); finish(3, 32'h0002_0000, 1'b0);

        // Requester 2 withdraws before being granted.
        REQ_VALID = 4'b0001;
        grant(0);
        REQ_VALID = 4'b0100;
        tick(); tick();
        REQ_VALID = 4'b1000;
        finish(0, 32'h0000_8000, 1'b0);
        grant(3);
        REQ_VALID = '0;
        finish(3, 32'h0002_0000, 1'b0);

        // Backpressure with requester 2 waiting.
        set_req(2, 32'h0003_0000, 16'hC000);
        REQ_VALID = 4'b0100;
        grant(2);
        begin
            int n;
            n = 0;
            while (!RES_VALID && n < 40) begin
                tick();
                n++;
            end
        end
        #1;
        hold_d  = RES_DATA;
        hold_id = RES_ID;
        chk("bp_data", hold_d, 32'h0002_4000);
        for (int c = 0; c < 5; c++) begin
            chk("bp_valid", {31'b0, RES_VALID}, 32'd1);
            chk("bp_stable_d", RES_DATA, 32'h0002_4000);
            chk("bp_stable_id", {30'b0, RES_ID}, 32'd2);
            chk("bp_ready", {28'b0, REQ_READY}, 32'd0);
            chk("bp_busy", {31'b0, BUSY}, 32'd1);
            tick();
            #1;
        end
        RES_READY = 1'b1;
        tick();
        RES_READY = 1'b0;
        #1;
        chk("bp_regrant", {28'b0, REQ_READY}, 32'h4);
        tick();
        REQ_VALID = '0;
        finish(2, 32'h0002_4000, 1'b0);

        // Reset at cnt=7 of an operation from requester 3.
        set_req(3, 32'h0001_0000, 16'hFFFF);
        REQ_VALID = 4'b1000;
        grant(3);
        REQ_VALID = '0;
        for (int c = 0; c < 7; c++) tick();
        RST = 1'b1;
        REQ_VALID = 4'b1010;
        #1;
        chk("rst_force_ready", {28'b0, REQ_READY}, 32'd0);
        tick();
        RST = 1'b0;
        REQ_VALID = '0;
        #1;
        chk("mid_busy", {31'b0, BUSY}, 32'd0);
        chk("mid_valid", {31'b0, RES_VALID}, 32'd0);
        chk("mid_data", RES_DATA, 32'd0);
        chk("mid_id", {30'b0, RES_ID}, 32'd0);
        for (int c = 0; c < 20; c++) begin
            tick();
            #1;
            chk("mid_no_res", {31'b0, RES_VALID}, 32'd0);
        end
        set_req(1, 32'h0001_0000, 16'hC000);
        REQ_VALID = 4'b1010;
        grant(1);
        REQ_VALID = '0;
        finish(1, 32'h0000_C000, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
